dmem_arbiter: RTL

- Shares the single byte-addressed, 64-byte, little-endian data memory between two requesters: port 0 (CPU load/store) and port 1 (loader/debug).
- Uses a valid/ready request handshake and round-robin arbitration.
- Sequences each 64-bit access as one explicit memory cycle and returns a one-cycle response pulse.
- Sits between the requesters and the data memory, and drives that memory's address, write data, write strobe and read strobe.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 16 +
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids
// and the last legal doubleword start address.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned DMEM_BYTES = 64;

    function automatic logic [63:0] addr_last(input int unsigned mem_bytes);
        return 64'(mem_bytes) - 64'd8;
    endfunction

    localparam logic [63:0] DMEM_ADDR_LAST = addr_last(DMEM_BYTES);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// port named by rr_ptr.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant0,
    output logic grant1
);

    assign grant0 = valid0 && (!valid1 || (rr_ptr == PORT_CPU));
    assign grant1 = valid1 && (!valid0 || (rr_ptr == PORT_DBG));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the 64-byte data memory: accepts one request at a time,
// runs a single memory cycle for it and returns a one-cycle response pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned MEM_BYTES = DMEM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(addr_last(MEM_BYTES));

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                port_q, port_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
    logic                resp0_valid_q, resp0_valid_d;
    logic [DATA_W-1:0]   resp0_rdata_q, resp0_rdata_d;
    logic                resp0_err_q, resp0_err_d;
    logic                resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0]   resp1_rdata_q, resp1_rdata_d;
    logic                resp1_err_q, resp1_err_d;

    logic                grant0, grant1;
    logic                win_port;
    logic [DATA_W-1:0]   rdata_d;
    logic                err_d;
    logic                in_access, in_resp;

    rr_arbiter2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr_q),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = (state_q == ST_IDLE) && grant0 && !reset;
    assign req1_ready = (state_q == ST_IDLE) && grant1 && !reset;
    assign win_port   = grant1;

    // Next-state, request latch and registered-output computation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        port_d   = port_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    port_d   = win_port;
                    write_d  = win_port ? req1_write : req0_write;
                    addr_d   = win_port ? req1_addr  : req0_addr;
                    wdata_d  = win_port ? req1_wdata : req0_wdata;
                    rr_ptr_d = ~win_port;
                    // Unsigned compare also catches addresses with high bits set.
                    if (addr_d > ADDR_LAST) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (write_q) begin
                    rdata_d = '0;
                end else begin
                    rdata_d = mem_rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_access     = (state_d == ST_ACCESS);
        in_resp       = (state_d == ST_RESP);
        mem_addr_d    = in_access ? addr_d  : '0;
        mem_wdata_d   = in_access ? wdata_d : '0;
        mem_write_d   = in_access && write_d;
        mem_read_d    = in_access && !write_d;
        resp0_valid_d = in_resp && (port_d == PORT_CPU);
        resp1_valid_d = in_resp && (port_d == PORT_DBG);
        resp0_rdata_d = resp0_valid_d ? rdata_d : '0;
        resp1_rdata_d = resp1_valid_d ? rdata_d : '0;
        resp0_err_d   = resp0_valid_d && err_d;
        resp1_err_d   = resp1_valid_d && err_d;
    end

    // State and output registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= PORT_CPU;
            port_q        <= PORT_CPU;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp0_err_q   <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp1_rdata_q <= '0;
            resp1_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            port_q        <= port_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            resp0_valid_q <= resp0_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp0_err_q   <= resp0_err_d;
            resp1_valid_q <= resp1_valid_d;
            resp1_rdata_q <= resp1_rdata_d;
            resp1_err_q   <= resp1_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign resp0_valid = resp0_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp0_err   = resp0_err_q;
    assign resp1_valid = resp1_valid_q;
    assign resp1_rdata = resp1_rdata_q;
    assign resp1_err   = resp1_err_q;

endmodule
